// File: rtl/pong_round_controller.sv
`timescale 1ns/1ps
// pong_round_controller
//   Game-flow sequencer for pong: READY -> SERVE -> PLAY <-> PAUSE, PLAY -> DEAD
//   -> SERVE or OVER. Tracks remaining balls and the hit score, and drives the
//   datapath strobes. Frame timing comes from the one-clk game_clk tick.
//   Optional feature: define PONG_DEBOUNCE_EN to debounce the synchronized
//   buttons for DEBOUNCE_CYC clk cycles before they are used.
module pong_round_controller #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 120,
  parameter int unsigned DEAD_FRAMES  = 60,
  parameter int unsigned SCORE_W      = 10,
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_clk,
  input  logic               ready_button,
  input  logic               right,
  input  logic               left,
  input  logic               sig_dead,
  input  logic               sig_hit,
  output logic               ready_sig,
  output logic               start_sig,
  output logic               play_sig,
  output logic               pause_sig,
  output logic               left_sig,
  output logic               right_sig,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  typedef enum logic [2:0] {
    ST_READY,
    ST_SERVE,
    ST_PLAY,
    ST_PAUSE,
    ST_DEAD,
    ST_OVER
  } state_e;

  // Button vector layout everywhere below: [2] ready, [1] left, [0] right.
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] sync_pressed;
  logic [2:0] btn_pressed;

  // Two-flop synchronizers on the raw active-low keys; reset to "released".
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= {ready_button, left, right};
      sync2_q <= sync1_q;
    end
  end

  assign sync_pressed = ~sync2_q;

`ifdef PONG_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  logic [2:0]      deb_q, deb_d;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];

  // Debounce: accept a new level only after it differs from the held state
  // for DEBOUNCE_CYC consecutive cycles; any return to the held level restarts.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync_pressed[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          deb_d[i] = sync_pressed[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state and counters.
  // NOTE: the small counter array is reset like plain flops; it is control state, not a RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign btn_pressed = deb_q;
`else
  logic unused_debounce_cyc;
  assign unused_debounce_cyc = ^DEBOUNCE_CYC;
  assign btn_pressed         = sync_pressed;
`endif

  logic                rdy_prev_q;
  logic                press_rdy;
  state_e              state_q, state_d;
  logic [7:0]          frame_q, frame_d;
  logic [2:0]          lives_q, lives_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                start_q, left_q, right_q;

  assign press_rdy = btn_pressed[2] & ~rdy_prev_q;

  // Next-state, frame counter, lives and score.
  always_comb begin
    state_d = state_q;
    frame_d = game_clk ? frame_q + 8'd1 : frame_q;
    lives_d = lives_q;
    score_d = score_q;

    unique case (state_q)
      ST_READY: begin
        if (press_rdy) begin
          state_d = ST_SERVE;
          lives_d = 3'(LIVES);
          score_d = '0;
        end
      end
      ST_SERVE: begin
        if (game_clk && frame_q == 8'(SERVE_FRAMES - 1)) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (sig_hit && score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
        // A miss outranks a simultaneous pause request.
        if (sig_dead) begin
          state_d = ST_DEAD;
          if (lives_q != '0) lives_d = lives_q - 3'd1;
        end else if (press_rdy) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        frame_d = frame_q;
        if (press_rdy) state_d = ST_PLAY;
      end
      ST_DEAD: begin
        if (game_clk && frame_q == 8'(DEAD_FRAMES - 1)) begin
          state_d = (lives_q == '0) ? ST_OVER : ST_SERVE;
        end
      end
      ST_OVER: begin
        if (press_rdy) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase

    if (state_d != state_q) frame_d = '0;
  end

  // State, counters and registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_READY;
      frame_q    <= '0;
      lives_q    <= 3'(LIVES);
      score_q    <= '0;
      rdy_prev_q <= 1'b0;
      start_q    <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      rdy_prev_q <= btn_pressed[2];
      start_q    <= (state_d == ST_SERVE) && (state_q != ST_SERVE);
      left_q     <= (state_d == ST_PLAY) & btn_pressed[1] & ~btn_pressed[0];
      right_q    <= (state_d == ST_PLAY) & btn_pressed[0] & ~btn_pressed[1];
    end
  end

  assign ready_sig = (state_q == ST_READY);
  assign play_sig  = (state_q == ST_PLAY);
  assign pause_sig = (state_q == ST_PAUSE);
  assign game_over = (state_q == ST_OVER);
  assign start_sig = start_q;
  assign left_sig  = left_q;
  assign right_sig = right_q;
  assign lives     = lives_q;
  assign score     = score_q;

endmodule
